// File: rtl/risc16b_dbus_io_pkg.sv
// Shared definitions for the risc16b data-bus I/O responder: register map,
// STATUS/TCTRL bit positions, the UART transmitter state type and a
// byte-lane merge helper.
package risc16b_io_pkg;

  // Register byte offsets inside the 32-byte I/O window
  localparam logic [4:0] IO_TXDATA = 5'h00;
  localparam logic [4:0] IO_STATUS = 5'h02;
  localparam logic [4:0] IO_GPIO   = 5'h04;
  localparam logic [4:0] IO_CYCLE  = 5'h06;
  localparam logic [4:0] IO_TCMP   = 5'h08;
  localparam logic [4:0] IO_TCTRL  = 5'h0A;

  // STATUS bit positions (count occupies bits 7:3)
  localparam int ST_FULL    = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_CNT_LSB = 3;

  // TCTRL bit positions
  localparam int TC_EN   = 0;
  localparam int TC_IE   = 1;
  localparam int TC_FLAG = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // True when the word index selects the register at byte offset off
  function automatic logic is_reg(input logic [3:0] idx, input logic [4:0] off);
    return idx == off[4:1];
  endfunction

  // Big-endian lane merge: we[0] carries bits 15:8, we[1] carries bits 7:0
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                              input logic [15:0] data,
                                              input logic [1:0]  we);
    logic [15:0] result;
    result = old_val;
    if (we[0]) result[15:8] = data[15:8];
    if (we[1]) result[7:0]  = data[7:0];
    return result;
  endfunction

endpackage

// File: rtl/risc16b_dbus_io_if.sv
// Data-bus signals between the risc16b core (master) and the I/O
// responder (slave). Read data and hit are combinational from the slave.
interface risc16b_dbus_io_if;
  logic [15:0] d_addr;
  logic        d_oe;
  logic [15:0] d_dout;
  logic [1:0]  d_we;
  logic [15:0] io_rdata;
  logic        io_hit;

  modport master (
    output d_addr, d_oe, d_dout, d_we,
    input  io_rdata, io_hit
  );

  modport slave (
    input  d_addr, d_oe, d_dout, d_we,
    output io_rdata, io_hit
  );
endinterface

// File: rtl/risc16b_dbus_io_tx_fifo.sv
// Synchronous FIFO buffering UART transmit bytes. A push while full is
// dropped even if a pop happens on the same edge; the caller detects the
// drop from full.
module io_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since cnt gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/risc16b_dbus_io.sv
// Memory-mapped I/O responder for the risc16b data bus: UART transmitter
// (8N1, FIFO buffered), GPIO output register, free-running cycle counter
// and a compare timer. Reads are combinational, writes land on the next edge.
module risc16b_dbus_io
  import risc16b_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  risc16b_dbus_io_if.slave        bus,
  output logic                    txd,
  output logic [15:0]             gpio_out,
  output logic                    irq
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    idx;
  logic          hit;
  logic          wr;
  logic [15:0]   rdata;

  logic [15:0]   cycle;
  logic [15:0]   tcmp;
  logic          t_en;
  logic          t_ie;
  logic          t_flag;
  logic          ovr;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_din;
  logic [7:0]    fifo_dout;
  logic [FW-1:0] fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [4:0]    cnt5;

  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          busy;

  logic          unused_bits;

  assign idx   = bus.d_addr[4:1];
  assign hit   = (bus.d_addr[15:5] == BASE_ADDR[15:5]) & (bus.d_oe | (|bus.d_we));
  assign wr    = hit & (|bus.d_we);
  assign busy  = (state != TX_IDLE);
  assign cnt5  = 5'(fifo_cnt);
  assign irq   = t_flag & t_ie;
  assign unused_bits = bus.d_addr[0];

  assign bus.io_hit   = hit;
  assign bus.io_rdata = rdata;

  // An even-byte store pushes the high byte; odd-byte or word stores push the low byte
  assign fifo_push = wr & is_reg(idx, IO_TXDATA);
  assign fifo_din  = (bus.d_we == 2'b01) ? bus.d_dout[15:8] : bus.d_dout[7:0];
  assign fifo_pop  = (state == TX_IDLE) & ~fifo_empty;

  io_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read mux: only a load that hits the window returns data, everything else reads zero
  always_comb begin
    rdata = 16'h0000;
    if (hit && bus.d_oe) begin
      case (1'b1)
        is_reg(idx, IO_STATUS): rdata = {8'h00, cnt5, ovr, busy, fifo_full};
        is_reg(idx, IO_GPIO):   rdata = gpio_out;
        is_reg(idx, IO_CYCLE):  rdata = cycle;
        is_reg(idx, IO_TCMP):   rdata = tcmp;
        is_reg(idx, IO_TCTRL):  rdata = {13'h0000, t_flag, t_ie, t_en};
        default:                rdata = 16'h0000;
      endcase
    end
  end

  // Sticky overrun: a push into a full FIFO sets it, writing STATUS bit 2 clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (fifo_push && fifo_full) begin
      ovr <= 1'b1;
    end else if (wr && is_reg(idx, IO_STATUS) && bus.d_we[1] && bus.d_dout[ST_OVR]) begin
      ovr <= 1'b0;
    end
  end

  // GPIO, cycle counter and compare timer; a timer hit outranks a flag clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= 16'h0000;
      cycle    <= 16'h0000;
      tcmp     <= 16'h0000;
      t_en     <= 1'b0;
      t_ie     <= 1'b0;
      t_flag   <= 1'b0;
    end else begin
      if (wr && is_reg(idx, IO_GPIO))
        gpio_out <= merge_lanes(gpio_out, bus.d_dout, bus.d_we);

      if (wr && is_reg(idx, IO_CYCLE))
        cycle <= merge_lanes(cycle, bus.d_dout, bus.d_we);
      else
        cycle <= cycle + 1'b1;

      if (wr && is_reg(idx, IO_TCMP))
        tcmp <= merge_lanes(tcmp, bus.d_dout, bus.d_we);

      if (wr && is_reg(idx, IO_TCTRL) && bus.d_we[1]) begin
        t_en <= bus.d_dout[TC_EN];
        t_ie <= bus.d_dout[TC_IE];
      end

      if (t_en && (cycle == tcmp))
        t_flag <= 1'b1;
      else if (wr && is_reg(idx, IO_TCTRL) && bus.d_we[1] && bus.d_dout[TC_FLAG])
        t_flag <= 1'b0;
    end
  end

  // UART transmit FSM: start bit, 8 data bits LSB first, stop bit, each CLK_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      txd     <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            shreg <= fifo_dout;
            baud  <= BW'(CLK_DIV - 1);
            txd   <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (baud == '0) begin
            baud    <= BW'(CLK_DIV - 1);
            bit_cnt <= 3'd0;
            txd     <= shreg[0];
            state   <= TX_DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        TX_DATA: begin
          if (baud == '0) begin
            baud <= BW'(CLK_DIV - 1);
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        TX_STOP: begin
          txd <= 1'b1;
          if (baud == '0)
            state <= TX_IDLE;
          else
            baud <= baud - 1'b1;
        end
        default: begin
          txd   <= 1'b1;
          state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
